// File: rtl/pcw_line_fetcher_if.sv
// Memory request port between pcw_line_fetcher and the shared SDRAM/BRAM arbiter.
// master drives the req/addr pair; slave answers with ack and read data.
interface pcw_line_fetcher_if #(
    parameter int ADDR_W = 17
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [7:0]        mem_data;

    modport master (output mem_req, mem_addr, input mem_ack, mem_data);
    modport slave  (input mem_req, mem_addr, output mem_ack, mem_data);
endinterface

// File: rtl/pcw_line_fetcher.sv
// PCW video line fetcher: roller-RAM lookup, ping-pong line buffer prefetch and 1/2/4 bpp serialiser.
// Optional macro PCW_UNDERRUN_REPEAT_EN: after an underrun the previous complete line is shown again.
module pcw_line_fetcher #(
    parameter int H_BYTES    = 90,
    parameter int ADDR_W     = 17,
    parameter int BUF_AW     = 7,
    parameter int ROW_STRIDE = 8
) (
    input  logic                      clk_sys,
    input  logic                      reset,
    input  logic                      pix_ce,
    input  logic                      line_start,
    input  logic [7:0]                line_y,
    input  logic                      active,
    input  logic [7:0]                roller_ptr,
    input  logic [7:0]                yscroll,
    input  logic [1:0]                bpp_mode,
    input  logic                      inverse,
    input  logic                      disable_vid,
    pcw_line_fetcher_if.master        mem,
    output logic [3:0]                colour,
    output logic                      underrun
);
    localparam int PW = BUF_AW + 4;
    localparam logic [PW-1:0]     PIX_MAX = PW'(8 * H_BYTES);
    localparam logic [BUF_AW-1:0] LAST_K  = BUF_AW'(H_BYTES - 1);

    typedef enum logic [2:0] {IDLE, ROLL_LO, ROLL_HI, FETCH, DONE} state_t;

    state_t            state;
    logic              rd_bank;
    logic              wr_bank;
    logic [BUF_AW-1:0] k;
    logic [7:0]        roller_lo;
    logic [7:0]        line_buf [2**(BUF_AW+1)];
    logic [PW-1:0]     p;

    logic        acked;
    logic        busy;
    logic        final_ack;
    logic        buf_we;
    logic [7:0]  row;
    logic [15:0] roller;
    logic [16:0] roll_addr;
    logic [16:0] line_addr;
    logic [7:0]  cur_byte;
    logic [7:0]  sh1;
    logic [7:0]  sh2;
    logic [3:0]  pixel;

    assign acked     = mem.mem_req & mem.mem_ack;
    assign busy      = (state == ROLL_LO) || (state == ROLL_HI) || (state == FETCH);
    assign final_ack = (state == FETCH) && acked && (k == LAST_K);
    assign buf_we    = (state == FETCH) && acked && (!line_start || k == LAST_K);
    assign row       = line_y + 8'd1 + yscroll;
    assign roll_addr = {roller_ptr, 9'b0} + {8'b0, row, 1'b0};
    assign roller    = {mem.mem_data, roller_lo};
    assign line_addr = {roller[15:3], 1'b0, roller[2:0]};

    // A line_start always forces one idle request cycle; ROLL_LO issues the request once mem_req is low.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state        <= IDLE;
            mem.mem_req  <= 1'b0;
            mem.mem_addr <= '0;
            underrun     <= 1'b0;
            rd_bank      <= 1'b0;
            wr_bank      <= 1'b1;
            k            <= '0;
            roller_lo    <= '0;
        end else if (line_start) begin
            underrun    <= underrun | (busy & ~final_ack);
`ifdef PCW_UNDERRUN_REPEAT_EN
            if (!busy || final_ack) begin
                rd_bank <= wr_bank;
                wr_bank <= rd_bank;
            end
`else
            rd_bank <= wr_bank;
            wr_bank <= rd_bank;
`endif
            state       <= ROLL_LO;
            mem.mem_req <= 1'b0;
        end else begin
            case (state)
                ROLL_LO: begin
                    if (!mem.mem_req) begin
                        mem.mem_req  <= 1'b1;
                        mem.mem_addr <= ADDR_W'(roll_addr);
                    end else if (mem.mem_ack) begin
                        roller_lo    <= mem.mem_data;
                        mem.mem_addr <= mem.mem_addr + ADDR_W'(1);
                        state        <= ROLL_HI;
                    end
                end
                ROLL_HI: begin
                    if (acked) begin
                        mem.mem_addr <= ADDR_W'(line_addr);
                        k            <= '0;
                        state        <= FETCH;
                    end
                end
                FETCH: begin
                    if (acked) begin
                        if (k == LAST_K) begin
                            mem.mem_req <= 1'b0;
                            state       <= DONE;
                        end else begin
                            k            <= k + BUF_AW'(1);
                            mem.mem_addr <= mem.mem_addr + ADDR_W'(ROW_STRIDE);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (buf_we)
            line_buf[{wr_bank, k}] <= mem.mem_data;
    end

    assign cur_byte = line_buf[{rd_bank, p[BUF_AW+2:3]}];
    assign sh1      = cur_byte << p[2:0];
    assign sh2      = cur_byte << {p[2:1], 1'b0};

    always_comb begin
        pixel = '0;
        if (p != PIX_MAX) begin
            case (bpp_mode)
                2'd1:    pixel = {sh2[7:6], sh2[7:6]};
                2'd2:    pixel = p[2] ? cur_byte[3:0] : cur_byte[7:4];
                default: pixel = {4{sh1[7]}};
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            p      <= '0;
            colour <= '0;
        end else begin
            if (!active)
                p <= '0;
            else if (pix_ce && p != PIX_MAX)
                p <= p + PW'(1);
            if (pix_ce) begin
                if (disable_vid || !active)
                    colour <= {4{inverse}};
                else
                    colour <= inverse ? ~pixel : pixel;
            end
        end
    end
endmodule

// File: tb/tb_pcw_line_fetcher.sv
// Directed bench for pcw_line_fetcher: roller lookup, fetch addressing, stall, serialiser modes, underrun, reset.
// Expectations follow the macro PCW_UNDERRUN_REPEAT_EN when it is defined for the build.
module tb_pcw_line_fetcher;
    logic       clk_sys = 1'b0;
    logic       reset = 1'b1;
    logic       pix_ce = 1'b0;
    logic       line_start = 1'b0;
    logic [7:0] line_y = '0;
    logic       active = 1'b0;
    logic [7:0] roller_ptr = '0;
    logic [7:0] yscroll = '0;
    logic [1:0] bpp_mode = '0;
    logic       inverse = 1'b0;
    logic       disable_vid = 1'b0;
    logic [3:0] colour;
    logic       underrun;

    int errors = 0;
    int checks = 0;

    pcw_line_fetcher_if #(.ADDR_W(17)) mem_bus ();

    pcw_line_fetcher #(
        .H_BYTES(90), .ADDR_W(17), .BUF_AW(7), .ROW_STRIDE(8)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .pix_ce(pix_ce), .line_start(line_start),
        .line_y(line_y), .active(active), .roller_ptr(roller_ptr), .yscroll(yscroll),
        .bpp_mode(bpp_mode), .inverse(inverse), .disable_vid(disable_vid),
        .mem(mem_bus), .colour(colour), .underrun(underrun)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic logic [7:0] line_byte(input int tag, input int k);
        if (k == 0) begin
            case (tag)
                1: return 8'hA5;
                2: return 8'h3C;
                3: return 8'h81;
                4: return 8'h6E;
                default: return 8'h00;
            endcase
        end
        return 8'((tag * 37 + k * 11) & 255);
    endfunction

    function automatic logic [31:0] exp_1bpp(input logic [7:0] b);
        logic [31:0] r = '0;
        for (int i = 0; i < 8; i++) r[31-4*i -: 4] = {4{b[7-i]}};
        return r;
    endfunction

    function automatic logic [31:0] exp_4bpp(input logic [7:0] b);
        return {b[7:4], b[7:4], b[7:4], b[7:4], b[3:0], b[3:0], b[3:0], b[3:0]};
    endfunction

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (mem_bus.mem_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_sys);
        end
    endtask

    task automatic serve(input logic [7:0] d);
        mem_bus.mem_ack  = 1'b1;
        mem_bus.mem_data = d;
        @(negedge clk_sys);
        mem_bus.mem_ack  = 1'b0;
    endtask

    task automatic fetch_line(input int tag, input int n, output int to);
        bit ok;
        to = 0;
        for (int i = -2; i < n; i++) begin
            wait_req(ok);
            if (!ok) begin
                to++;
                return;
            end
            serve(i < 0 ? 8'h00 : line_byte(tag, i));
        end
    endtask

    task automatic pulse_line_start();
        line_start = 1'b1;
        @(negedge clk_sys);
        line_start = 1'b0;
    endtask

    task automatic pix(output logic [3:0] c);
        pix_ce = 1'b1;
        @(negedge clk_sys);
        pix_ce = 1'b0;
        c = colour;
        @(negedge clk_sys);
    endtask

    task automatic pix8(output logic [31:0] v);
        logic [3:0] c;
        v = '0;
        for (int i = 0; i < 8; i++) begin
            pix(c);
            v = {v[27:0], c};
        end
    endtask

    task automatic new_line();
        active = 1'b0;
        @(negedge clk_sys);
        @(negedge clk_sys);
        active = 1'b1;
    endtask

    task automatic test_reset();
        mem_bus.mem_ack  = 1'b0;
        mem_bus.mem_data = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk_sys);
        checks++;
        if ({mem_bus.mem_req, mem_bus.mem_addr, colour, underrun} !== 23'd0) begin
            errors++;
            $display("FAIL reset_state: got req=%b addr=%h colour=%h underrun=%b required all zero",
                     mem_bus.mem_req, mem_bus.mem_addr, colour, underrun);
        end
        reset = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic test_roller_fetch();
        bit ok;
        int to = 0;
        int bad_addr = 0;
        bit stall_bad = 1'b0;
        logic [16:0] a, expa, last_a;
        roller_ptr = 8'h5B; yscroll = 8'h00; line_y = 8'h00;
        pulse_line_start();
        wait_req(ok);
        checks++;
        if (!ok || mem_bus.mem_addr !== 17'h0B602) begin
            errors++;
            $display("FAIL roll_lo_addr: got %h (req seen %0d) required 0b602", mem_bus.mem_addr, ok);
        end
        serve(8'h35);
        wait_req(ok);
        checks++;
        if (!ok || mem_bus.mem_addr !== 17'h0B603) begin
            errors++;
            $display("FAIL roll_hi_addr: got %h (req seen %0d) required 0b603", mem_bus.mem_addr, ok);
        end
        serve(8'h12);
        last_a = '0;
        for (int k = 0; k < 90; k++) begin
            wait_req(ok);
            if (!ok) begin
                to++;
                break;
            end
            a = mem_bus.mem_addr;
            expa = 17'h02465 + 17'(8 * k);
            if (a !== expa) bad_addr++;
            last_a = a;
            if (k == 3) begin
                repeat (10) begin
                    @(negedge clk_sys);
                    if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== a) stall_bad = 1'b1;
                end
                serve(line_byte(1, k));
                checks++;
                if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== a + 17'd8) begin
                    errors++;
                    $display("FAIL stall_advance: got req=%b addr=%h required req=1 addr=%h",
                             mem_bus.mem_req, mem_bus.mem_addr, a + 17'd8);
                end
            end else begin
                serve(line_byte(1, k));
            end
        end
        checks++;
        if (to != 0) begin
            errors++;
            $display("FAIL fetch_timeout: got %0d timeouts required 0", to);
        end
        checks++;
        if (stall_bad) begin
            errors++;
            $display("FAIL stall_hold: got req/addr change during stall required stable at %h", a);
        end
        checks++;
        if (bad_addr != 0) begin
            errors++;
            $display("FAIL fetch_addrs: got %0d wrong addresses required 0", bad_addr);
        end
        checks++;
        if (last_a !== 17'h0272D) begin
            errors++;
            $display("FAIL last_addr: got %h required 0272d", last_a);
        end
        checks++;
        if (mem_bus.mem_req !== 1'b0 || underrun !== 1'b0) begin
            errors++;
            $display("FAIL fetch_done: got req=%b underrun=%b required 0 0", mem_bus.mem_req, underrun);
        end
        ok = 1'b0;
        repeat (5) begin
            @(negedge clk_sys);
            if (mem_bus.mem_req !== 1'b0) ok = 1'b1;
        end
        checks++;
        if (ok) begin
            errors++;
            $display("FAIL done_idle: got extra request required none after DONE");
        end
    endtask

    task automatic test_wrap(input logic [7:0] rp, input logic [7:0] ly, input logic [7:0] ys,
                             input logic [16:0] expa, input int tag);
        bit ok;
        int to;
        roller_ptr = rp; line_y = ly; yscroll = ys;
        pulse_line_start();
        wait_req(ok);
        checks++;
        if (!ok || mem_bus.mem_addr !== expa) begin
            errors++;
            $display("FAIL wrap_addr: got %h (req seen %0d) required %h", mem_bus.mem_addr, ok, expa);
        end
        fetch_line(tag, 90, to);
        checks++;
        if (to != 0 || underrun !== 1'b0) begin
            errors++;
            $display("FAIL wrap_fetch: got timeouts=%0d underrun=%b required 0 0", to, underrun);
        end
    endtask

    task automatic test_serialiser();
        logic [31:0] v;
        logic [3:0] c;
        logic [31:0] e;
        inverse = 1'b0; disable_vid = 1'b0;
        bpp_mode = 2'd0; new_line(); pix8(v);
        checks++;
        if (v !== 32'hF0F00F0F) begin errors++; $display("FAIL ser_1bpp: got %h required f0f00f0f", v); end
        pix8(v); e = exp_1bpp(line_byte(1, 1));
        checks++;
        if (v !== e) begin errors++; $display("FAIL ser_1bpp_byte1: got %h required %h", v, e); end
        bpp_mode = 2'd1; new_line(); pix8(v);
        checks++;
        if (v !== 32'hAAAA5555) begin errors++; $display("FAIL ser_2bpp: got %h required aaaa5555", v); end
        bpp_mode = 2'd2; new_line(); pix8(v);
        checks++;
        if (v !== 32'hAAAA5555) begin errors++; $display("FAIL ser_4bpp: got %h required aaaa5555", v); end
        pix8(v); e = exp_4bpp(line_byte(1, 1));
        checks++;
        if (v !== e) begin errors++; $display("FAIL ser_4bpp_byte1: got %h required %h", v, e); end
        bpp_mode = 2'd0; inverse = 1'b1; new_line(); pix8(v);
        checks++;
        if (v !== 32'h0F0FF0F0) begin errors++; $display("FAIL ser_inverse: got %h required 0f0ff0f0", v); end
        inverse = 1'b0; new_line();
        for (int i = 0; i < 4; i++) begin pix(c); v = {v[27:0], c}; end
        bpp_mode = 2'd2;
        for (int i = 0; i < 4; i++) begin pix(c); v = {v[27:0], c}; end
        checks++;
        if (v !== 32'hF0F05555) begin errors++; $display("FAIL ser_mode_change: got %h required f0f05555", v); end
        bpp_mode = 2'd0; disable_vid = 1'b1; new_line(); pix(c);
        checks++;
        if (c !== 4'h0) begin errors++; $display("FAIL ser_disable: got %h required 0", c); end
        inverse = 1'b1; pix(c);
        checks++;
        if (c !== 4'hF) begin errors++; $display("FAIL ser_disable_inv: got %h required f", c); end
        inverse = 1'b0; disable_vid = 1'b0; new_line();
        repeat (712) pix(c);
        pix(c);
        checks++;
        if (c !== 4'hF) begin errors++; $display("FAIL ser_last_byte: got %h required f", c); end
        repeat (7) pix(c);
        pix(c);
        checks++;
        if (c !== 4'h0) begin errors++; $display("FAIL ser_saturate: got %h required 0", c); end
        active = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic test_underrun();
        bit ok;
        int to;
        logic [31:0] v;
        logic [31:0] e;
        roller_ptr = 8'h10; yscroll = 8'h03; line_y = 8'h1F;
        pulse_line_start();
        fetch_line(4, 40, to);
        wait_req(ok);
        checks++;
        if (to != 0 || !ok) begin
            errors++;
            $display("FAIL underrun_setup: got timeouts=%0d pending=%0d required 0 1", to, ok);
        end
        line_y = 8'h20;
        pulse_line_start();
        checks++;
        if (underrun !== 1'b1 || mem_bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL underrun_gap: got underrun=%b req=%b required 1 0", underrun, mem_bus.mem_req);
        end
        serve(8'hEE);
        checks++;
        if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 17'h02048) begin
            errors++;
            $display("FAIL underrun_restart: got req=%b addr=%h required 1 02048", mem_bus.mem_req, mem_bus.mem_addr);
        end
`ifdef PCW_UNDERRUN_REPEAT_EN
        e = exp_4bpp(line_byte(3, 0));
`else
        e = exp_4bpp(line_byte(4, 0));
`endif
        bpp_mode = 2'd2; new_line(); pix8(v);
        checks++;
        if (v !== e) begin errors++; $display("FAIL underrun_bank: got %h required %h", v, e); end
        active = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic test_reset_mid_fetch();
        bit ok;
        int to;
        logic [3:0] c;
        fetch_line(5, 5, to);
        inverse = 1'b1; active = 1'b0;
        pix(c);
        checks++;
        if (c !== 4'hF || to != 0) begin
            errors++;
            $display("FAIL pre_reset: got colour=%h timeouts=%0d required f 0", c, to);
        end
        reset = 1'b1;
        @(negedge clk_sys);
        checks++;
        if ({mem_bus.mem_req, mem_bus.mem_addr, colour, underrun} !== 23'd0) begin
            errors++;
            $display("FAIL reset_mid_fetch: got req=%b addr=%h colour=%h underrun=%b required all zero",
                     mem_bus.mem_req, mem_bus.mem_addr, colour, underrun);
        end
        reset = 1'b0; inverse = 1'b0;
        ok = 1'b0;
        repeat (5) begin
            @(negedge clk_sys);
            if (mem_bus.mem_req !== 1'b0) ok = 1'b1;
        end
        checks++;
        if (ok) begin errors++; $display("FAIL reset_idle: got request after reset required none"); end
        pulse_line_start();
        wait_req(ok);
        checks++;
        if (!ok || underrun !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_start: got req seen=%0d underrun=%b required 1 0", ok, underrun);
        end
    endtask

    initial begin
        test_reset();
        test_roller_fetch();
        test_wrap(8'h00, 8'hFE, 8'h01, 17'h00000, 2);
        test_serialiser();
        test_wrap(8'hFF, 8'hFF, 8'h00, 17'h1FE00, 3);
        test_underrun();
        test_reset_mid_fetch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion required finish before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/pcw_line_fetcher.md
Name: pcw_line_fetcher

Overview:
Parametrised, prefetching successor to the PCW video pixel path. On each line start it reads the roller-RAM entry for the next line over a req/ack memory port. It then bursts that line's bitmap bytes into a ping-pong line buffer. While this happens, the current line is serialised from the other bank in 1, 2 or 4 bits-per-pixel mode. It sits between video_sync timing, the shared SDRAM/BRAM arbiter and the colour output stage.

Parameters:
H_BYTES, 90, bitmap bytes per line (720 px / 8)
ADDR_W, 17, memory address width
BUF_AW, 7, line-buffer bank address width; H_BYTES <= 2**BUF_AW required
ROW_STRIDE, 8, address increment between consecutive bytes of one line

Ports:
clk_sys  in  1  system clock (64 MHz)
reset  in  1  synchronous, active-high
pix_ce  in  1  pixel clock enable (1 in 4)
line_start  in  1  one-clk_sys pulse at start of hblank of line line_y
line_y  in  8  line currently being displayed
active  in  1  visible pixel area
roller_ptr  in  8  port F5 roller base
yscroll  in  8  port F6 scroll
bpp_mode  in  2  0=1bpp, 1=2bpp, 2=4bpp, 3=reserved (treated as 1bpp)
inverse  in  1  invert output
disable_vid  in  1  blank output
mem_req  out  1  memory request
mem_addr  out  ADDR_W  request address
mem_ack  in  1  data valid / request accepted
mem_data  in  8  read data, valid when mem_ack=1
colour  out  4  pixel colour
underrun  out  1  sticky: fetch incomplete at line_start

Behaviour:
- Reset: FSM=IDLE; mem_req=0; mem_addr=0; colour=0; underrun=0; rd_bank=0; wr_bank=1; both banks' contents undefined.
- Memory handshake: mem_req held high with mem_addr stable until a cycle where mem_ack=1. mem_data is captured in that cycle. The next request (new addr) may be presented in the following cycle. mem_ack while mem_req=0 is ignored.
- FSM states: IDLE, ROLL_LO, ROLL_HI, FETCH, DONE.
  - IDLE/DONE --line_start--> ROLL_LO.
  - ROLL_LO: addr = {roller_ptr,9'b0} + (((line_y+1+yscroll)&8'hFF)<<1), mod 2**ADDR_W. On ack: latch low byte -> ROLL_HI.
  - ROLL_HI: addr+1. On ack: latch high byte, form line_addr = {roller[15:3],1'b0,roller[2:0]}, k=0 -> FETCH.
  - FETCH: addr = line_addr + k*ROW_STRIDE (wraps mod 2**ADDR_W). On ack: write wr_bank[k], k++. Ack with k=H_BYTES-1 -> DONE.
- Bank swap on every line_start: rd_bank<=wr_bank, wr_bank<=rd_bank; fetch starts into the new wr_bank.
- line_start while FSM not IDLE/DONE is an underrun: set underrun (sticky until reset), drop mem_req for one cycle (abandoning any pending request; a late ack in that cycle is ignored), restart at ROLL_LO.
- line_start coincident with the final FETCH ack: byte is written, no underrun, swap proceeds.
- Serialiser: pixel counter p cleared while active=0. On pix_ce & active, output byte = rd_bank[p>>3], p++ (saturates at 8*H_BYTES; beyond that, pixel=0).
  - 1bpp: pixel = {4{bit[7-(p%8)]}}.
  - 2bpp: pair i=(p%8)>>1 is bits [7-2i:6-2i]; pixel = {pair,pair}.
  - 4bpp: nibble = p%8<4 ? [7:4] : [3:0].
- colour registered on pix_ce, 1 pix_ce latency:
  - disable_vid | ~active -> inverse ? 4'hF : 4'h0.
  - otherwise inverse ? ~pixel : pixel.
- bpp_mode sampled per pixel; a mid-line change takes effect on the next pixel.

Optional Feature:
PCW_UNDERRUN_REPEAT_EN
- Defined: on underrun no bank swap; rd_bank (previous complete line) is redisplayed, and the fetch restarts into the same wr_bank.
- Undefined: banks swap regardless; the partially filled bank is displayed (stale bytes beyond k).

Test Plan:
- Roller fetch: roller_ptr=0x5B, yscroll=0, line_y=0, pulse line_start -> requests at 0xB602 then 0xB603; supply 0x35,0x12 -> line_addr 0x2465; FETCH addrs 0x2465, 0x246D, ... 90 requests, last 0x2465+89*8=0x272D; ends in DONE.
- Wrap: line_y=0xFE, yscroll=0x01, roller_ptr=0 -> first request addr 0x00000. roller_ptr=0xFF, line_y=0xFF, yscroll=0 -> addr 0x1FE00 + 0 = 0x1FE00.
- Handshake stall: hold mem_ack=0 for 10 cycles in FETCH -> mem_addr/mem_req stable; ack -> addr advances by 8 next cycle.
- Serialiser: bank byte0=0xA5. 1bpp -> F,0,F,0,0,F,0,F. 2bpp -> A,A,A,A,5,5,5,5. 4bpp -> A,A,A,A,5,5,5,5. With inverse in 1bpp -> 0,F,0,F,F,0,F,0.
- Underrun: ack only 40 bytes, then line_start -> underrun=1, one-cycle mem_req gap, ROLL_LO restarts. Macro undefined: bank swapped. Macro defined: previous line redisplayed.
- Reset mid-FETCH: assert reset -> mem_req=0, FSM IDLE, underrun=0, colour=0 next cycle.
